// File: rtl/nios_pio_master_if.sv
// rtl/nios_pio_master_if.sv - command, response and Avalon-MM signal bundle for nios_pio_master
interface nios_pio_master_if #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_W-1:0]    cmd_address;
    logic [DATA_W-1:0]    cmd_data;
    logic [DATA_W-1:0]    cmd_mask;
    logic [TIMEOUT_W-1:0] cmd_timeout;

    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_error;

    logic [ADDR_W-1:0]    avm_address;
    logic                 avm_chipselect;
    logic                 avm_write_n;
    logic                 avm_read_n;
    logic [DATA_W-1:0]    avm_writedata;
    logic [DATA_W-1:0]    avm_readdata;
    logic                 avm_waitrequest;

    // master: the command initiator; slave: fabric requester plus the Avalon target
    modport master (
        input  cmd_valid, cmd_op, cmd_address, cmd_data, cmd_mask, cmd_timeout,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_error,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_address, cmd_data, cmd_mask, cmd_timeout,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_error,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/nios_pio_master.sv
// rtl/nios_pio_master.sv - single-command Avalon-MM initiator (write, read, poll with timeout)
module nios_pio_master #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    nios_pio_master_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_RDWAIT  = 3'd3;
    localparam logic [2:0] S_RSP_RSV = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [1:0] LAT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    logic [2:0]           state;
    logic                 poll_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    mask_q;
    logic [TIMEOUT_W-1:0] retry_q;
    logic [1:0]           lat_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic                 rsp_error_q;

    logic capture;
    logic hit;

    // Read data is valid in the acceptance cycle itself only for zero-latency slaves
    assign capture = ((state == S_READ) && !bus.avm_waitrequest && (READ_LATENCY == 0))
                  || ((state == S_RDWAIT) && (lat_q == 2'd0));
    assign hit     = ((bus.avm_readdata ^ data_q) & mask_q) == '0;

    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.avm_chipselect = (state == S_WRITE) || (state == S_READ);
    assign bus.avm_write_n    = (state != S_WRITE);
    assign bus.avm_read_n     = (state != S_READ);
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = data_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_error      = rsp_error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            poll_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            retry_q     <= '0;
            lat_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q  <= bus.cmd_address;
                        data_q  <= bus.cmd_data;
                        mask_q  <= bus.cmd_mask;
                        retry_q <= bus.cmd_timeout;
                        poll_q  <= (bus.cmd_op == OP_POLL);
                        case (bus.cmd_op)
                            OP_WRITE: state <= S_WRITE;
                            OP_READ,
                            OP_POLL:  state <= S_READ;
                            default: begin
                                state       <= S_RSP_RSV;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= '0;
                                rsp_error_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!bus.avm_waitrequest) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (!bus.avm_waitrequest && (READ_LATENCY != 0)) begin
                        state <= S_RDWAIT;
                        lat_q <= LAT_INIT;
                    end
                end
                S_RDWAIT: begin
                    if (lat_q != 2'd0) lat_q <= lat_q - 2'd1;
                end
                S_RSP_RSV: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase

            // Capture overrides the per-state next state: respond, or re-issue the poll read
            if (capture) begin
                if (!poll_q || hit || (retry_q == '0)) begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus.avm_readdata;
                    rsp_error_q <= poll_q && !hit;
                end else begin
                    retry_q <= retry_q - 1'b1;
                    state   <= S_READ;
                end
            end
        end
    end
endmodule

// File: tb/tb_nios_pio_master.sv
// tb/tb_nios_pio_master.sv - randomized self-checking bench for nios_pio_master with a PIO slave model
`timescale 1ns/1ps
module tb_nios_pio_master;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 16;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_PL  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_pio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)) bus ();

    nios_pio_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: addr 0 data (in_port looped from out_port), 4 set bits, 5 clear bits
    int unsigned rd_total = 0, wr_total = 0, wait_total = 0, strobe_total = 0;
    int unsigned excl_viol = 0, stab_viol = 0;
    logic [31:0] pio_out = 32'h0;
    int          wait_mode = 0;
    int          wait_fixed = 0;
    int          in_mode = 0;
    int unsigned poll_base = 0;
    bit          in_acc = 1'b0;
    int          wait_left = 0;
    logic [ADDR_W-1:0] sv_addr;
    logic [31:0]       sv_wd;
    logic              sv_rd_n, sv_wr_n;

    always @(negedge clk) begin
        logic strobe;
        strobe = bus.avm_chipselect && (!bus.avm_read_n || !bus.avm_write_n);
        if ((!bus.avm_read_n && !bus.avm_write_n) ||
            ((!bus.avm_read_n || !bus.avm_write_n) && !bus.avm_chipselect))
            excl_viol++;
        if (!reset_n || !strobe) begin
            in_acc = 1'b0;
            bus.avm_waitrequest = 1'b0;
        end else begin
            strobe_total++;
            if (!in_acc) begin
                in_acc    = 1'b1;
                wait_left = (wait_mode == 2) ? wait_fixed :
                            (wait_mode == 1) ? int'($urandom_range(0, 2)) : 0;
                sv_addr = bus.avm_address;
                sv_wd   = bus.avm_writedata;
                sv_rd_n = bus.avm_read_n;
                sv_wr_n = bus.avm_write_n;
            end else if (bus.avm_address !== sv_addr || bus.avm_writedata !== sv_wd ||
                         bus.avm_read_n !== sv_rd_n || bus.avm_write_n !== sv_wr_n) begin
                stab_viol++;
            end
            if (wait_left > 0) begin
                wait_left--;
                wait_total++;
                bus.avm_waitrequest = 1'b1;
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_acc = 1'b0;
                if (!bus.avm_write_n) begin
                    wr_total++;
                    case (bus.avm_address)
                        3'd0:    pio_out = bus.avm_writedata;
                        3'd4:    pio_out = pio_out | bus.avm_writedata;
                        3'd5:    pio_out = pio_out & ~bus.avm_writedata;
                        default: ;
                    endcase
                end else begin
                    if (bus.avm_address != 3'd0)
                        bus.avm_readdata = 32'h0;
                    else if (in_mode == 1)
                        bus.avm_readdata = (rd_total - poll_base >= 5) ? 32'h8000_0000 : 32'h0;
                    else
                        bus.avm_readdata = pio_out;
                    rd_total++;
                end
            end
        end
    end

    int unsigned rsp_total = 0, rsp_cyc = 0;
    logic [31:0] rsp_d;
    logic        rsp_e;
    logic        rsp_rdy;
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_total++;
            rsp_cyc = cyc;
            rsp_d   = bus.rsp_data;
            rsp_e   = bus.rsp_error;
            rsp_rdy = bus.cmd_ready;
        end
    end

    int unsigned issued = 0;
    int          last_lat, last_rd, last_wr, last_wait, last_stb;
    logic [31:0] last_d;
    logic        last_e;
    logic [31:0] ref_out = 32'h0;

    task automatic drive_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input logic [31:0] mask,
                             input logic [TIMEOUT_W-1:0] tmo);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_address = addr;
        bus.cmd_data    = data;
        bus.cmd_mask    = mask;
        bus.cmd_timeout = tmo;
        issued++;
    endtask

    task automatic scramble_cmd();
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'($urandom);
        bus.cmd_address = ADDR_W'($urandom);
        bus.cmd_data    = $urandom;
        bus.cmd_mask    = $urandom;
        bus.cmd_timeout = TIMEOUT_W'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input logic [TIMEOUT_W-1:0] tmo);
        int unsigned r0, w0, wt0, s0, rs0, c0;
        int guard;
        drive_cmd(op, addr, data, mask, tmo);
        r0 = rd_total; w0 = wr_total; wt0 = wait_total; s0 = strobe_total;
        rs0 = rsp_total; c0 = cyc;
        @(negedge clk); #1;
        scramble_cmd();
        guard = 0;
        while (rsp_total == rs0 && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        check("rsp_seen", 64'(rsp_total - rs0), 64'd1);
        last_lat  = int'(rsp_cyc - c0);
        last_d    = rsp_d;
        last_e    = rsp_e;
        last_rd   = int'(rd_total - r0);
        last_wr   = int'(wr_total - w0);
        last_wait = int'(wait_total - wt0);
        last_stb  = int'(strobe_total - s0);
    endtask

    // Expected outcome comes from register semantics and the cycle budget of each bus access
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] data, input logic [31:0] mask,
                          input logic [TIMEOUT_W-1:0] tmo);
        logic [31:0] cur, exp_d;
        logic        exp_e;
        int          n, exp_rd, exp_wr, exp_lat;
        cur = (addr == 3'd0) ? ref_out : 32'h0;
        run_cmd(op, addr, data, mask, tmo);
        exp_d = 32'h0; exp_e = 1'b0; exp_rd = 0; exp_wr = 0;
        case (op)
            OP_WR: begin
                exp_wr  = 1;
                exp_lat = 2 + last_wait;
                if (addr == 3'd0) ref_out = data;
                else if (addr == 3'd4) ref_out = ref_out | data;
                else if (addr == 3'd5) ref_out = ref_out & ~data;
            end
            OP_RD: begin
                exp_d   = cur;
                exp_rd  = 1;
                exp_lat = 3 + last_wait;
            end
            OP_PL: begin
                exp_d   = cur;
                exp_e   = ((cur & mask) != (data & mask));
                n       = exp_e ? int'(tmo) + 1 : 1;
                exp_rd  = n;
                exp_lat = 2 * n + 1 + last_wait;
            end
            default: begin
                exp_e   = 1'b1;
                exp_lat = 1;
            end
        endcase
        check({tag, "_data"}, 64'(last_d), 64'(exp_d));
        check({tag, "_err"},  64'(last_e), 64'(exp_e));
        check({tag, "_lat"},  64'(last_lat), 64'(exp_lat));
        check({tag, "_reads"}, 64'(last_rd), 64'(exp_rd));
        check({tag, "_writes"}, 64'(last_wr), 64'(exp_wr));
        if (op != OP_RSV) check({tag, "_ready_at_rsp"}, 64'(rsp_rdy), 64'd1);
    endtask

    initial begin
        int unsigned rs0, s0;
        int guard;
        logic [1:0]  op;
        logic [ADDR_W-1:0] addr;
        logic [31:0] data, mask;
        logic [2:0]  addr_pick [3];

        addr_pick[0] = 3'd0; addr_pick[1] = 3'd4; addr_pick[2] = 3'd5;
        scramble_cmd();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_chipselect", 64'(bus.avm_chipselect), 64'd0);
        check("rst_strobes", 64'({bus.avm_write_n, bus.avm_read_n}), 64'd3);
        check("rst_addr_wdata", 64'({bus.avm_address, bus.avm_writedata}), 64'd0);
        check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_error, bus.rsp_data}), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        reset_n = 1'b1;
        @(negedge clk); #1;

        do_cmd("wr_a5", OP_WR, 3'd0, 32'h0000_00A5, 32'h0, 16'd0);
        check("wr_strobe_len", 64'(last_stb), 64'd1);
        check("wr_lat_c2", 64'(last_lat), 64'd2);
        do_cmd("rd_a5", OP_RD, 3'd0, 32'h0, 32'h0, 16'd0);
        check("rd_lat_c3", 64'(last_lat), 64'd3);
        check("rd_a5_value", 64'(last_d), 64'h0000_00A5);

        do_cmd("set_0f", OP_WR, 3'd4, 32'h0000_000F, 32'h0, 16'd0);
        do_cmd("clr_05", OP_WR, 3'd5, 32'h0000_0005, 32'h0, 16'd0);
        do_cmd("rd_aa", OP_RD, 3'd0, 32'h0, 32'h0, 16'd0);
        check("setclr_value", 64'(last_d), 64'h0000_00AA);

        wait_mode = 2; wait_fixed = 3;
        do_cmd("rd_wait3", OP_RD, 3'd0, 32'h0, 32'h0, 16'd0);
        check("wait_strobe_len", 64'(last_stb), 64'd4);
        check("wait_lat_c6", 64'(last_lat), 64'd6);
        wait_mode = 0;

        in_mode = 1; poll_base = rd_total;
        run_cmd(OP_PL, 3'd0, 32'h8000_0000, 32'h8000_0000, 16'd10);
        check("pmatch_reads", 64'(last_rd), 64'd6);
        check("pmatch_err", 64'(last_e), 64'd0);
        check("pmatch_data", 64'(last_d), 64'h8000_0000);
        check("pmatch_lat", 64'(last_lat), 64'd13);
        in_mode = 0;

        do_cmd("ptimeout", OP_PL, 3'd0, 32'h0000_0055, 32'h0000_00FF, 16'd3);
        check("ptimeout_reads", 64'(last_rd), 64'd4);
        check("ptimeout_err", 64'(last_e), 64'd1);
        do_cmd("reserved", OP_RSV, 3'd2, 32'h1234, 32'h0, 16'd0);
        check("reserved_no_strobe", 64'(last_stb), 64'd0);
        check("reserved_lat_c1", 64'(last_lat), 64'd1);
        do_cmd("pmask0", OP_PL, 3'd0, 32'h1234_5678, 32'h0, 16'd5);
        check("pmask0_reads", 64'(last_rd), 64'd1);

        wait_mode = 1;
        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            addr = (op == OP_WR) ? addr_pick[$urandom_range(0, 2)] :
                   ($urandom_range(0, 3) == 0) ? addr_pick[$urandom_range(1, 2)] : 3'd0;
            data = $urandom;
            mask = $urandom & $urandom;
            if (op == OP_PL && $urandom_range(0, 1) == 1)
                data = ref_out ^ ($urandom & ~mask);
            do_cmd($sformatf("rnd%0d", i), op, addr, data, mask, TIMEOUT_W'($urandom_range(0, 3)));
        end
        wait_mode = 0;

        drive_cmd(OP_PL, 3'd0, ~ref_out, 32'hFFFF_FFFF, 16'd20);
        @(negedge clk); #1;
        scramble_cmd();
        guard = 0;
        while (!bus.avm_chipselect && guard < 10) begin
            @(negedge clk); #1;
            guard++;
        end
        check("rst_mid_strobe_seen", 64'(bus.avm_chipselect), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs_low", 64'(bus.avm_chipselect), 64'd0);
        check("rst_mid_strobes_high", 64'({bus.avm_write_n, bus.avm_read_n}), 64'd3);
        issued--;
        rs0 = rsp_total;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        s0 = strobe_total;
        repeat (60) @(negedge clk);
        #1;
        check("rst_mid_no_rsp", 64'(rsp_total - rs0), 64'd0);
        check("rst_mid_no_bus", 64'(strobe_total - s0), 64'd0);
        check("rst_mid_ready", 64'(bus.cmd_ready), 64'd1);
        do_cmd("post_rst_rd", OP_RD, 3'd0, 32'h0, 32'h0, 16'd0);

        check("strobe_exclusive", 64'(excl_viol), 64'd0);
        check("bus_stable_in_wait", 64'(stab_viol), 64'd0);
        check("rsp_count", 64'(rsp_total), 64'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nios_pio_master.md
# nios_pio_master

Avalon-MM command initiator that drives the register interface of a Nios PIO-style slave on behalf of fabric logic with no CPU attached. It accepts one command at a time (write, read, or poll-until-match with timeout), runs the bus transfer with waitrequest and fixed read latency, and returns a single-cycle response. It sits between control FSMs and any `nios_pio_*` slave, or other slaves using the same chipselect/write_n signalling.

## Interface
- `ADDR_W`, 3: slave word-address width.
- `DATA_W`, 32: data width.
- `READ_LATENCY`, 1: cycles from read acceptance to valid `avm_readdata`. Legal values are 0–3.
- `TIMEOUT_W`, 16: width of the poll retry count.

- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  opcode: 00 write, 01 read, 10 poll, 11 reserved.
- `cmd_address`  in  ADDR_W  target register.
- `cmd_data`  in  DATA_W  write data (write) or match value (poll).
- `cmd_mask`  in  DATA_W  poll compare mask.
- `cmd_timeout`  in  TIMEOUT_W  extra poll reads allowed.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_data`  out  DATA_W  captured read data; 0 for write.
- `rsp_error`  out  1  set on poll timeout or reserved opcode.
- `avm_address`  out  ADDR_W.
- `avm_chipselect`  out  1.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_read_n`  out  1  active-low read strobe.
- `avm_writedata`  out  DATA_W.
- `avm_readdata`  in  DATA_W.
- `avm_waitrequest`  in  1  tie to 0 for slaves without waitrequest.

## Operation
- **States:** IDLE, WRITE, READ, RDWAIT, RSP_RSV.
- **Command acceptance:** `cmd_address`, `cmd_data`, `cmd_mask` and `cmd_timeout` are registered on acceptance. The retry counter is loaded with `cmd_timeout`.
- **IDLE transitions:**
  - op 00 goes to WRITE.
  - op 01 and op 10 go to READ.
  - op 11 goes to RSP_RSV.
- **WRITE:**
  - Drives `avm_chipselect`=1, `avm_write_n`=0, address and writedata.
  - Holds while `avm_waitrequest`=1.
  - On the cycle it is low, the transfer completes. Next cycle: `rsp_valid`=1, `rsp_data`=0, `rsp_error`=0, return to IDLE.
- **READ:**
  - Drives `avm_chipselect`=1 and `avm_read_n`=0; holds while waitrequest=1.
  - Acceptance cycle T is the cycle with waitrequest=0.
  - If `READ_LATENCY`=0, `avm_readdata` is captured in T.
  - Otherwise go to RDWAIT; strobes deassert and data is captured at cycle T+`READ_LATENCY`.
- **Read completion (op 01):** the cycle after capture, `rsp_valid`=1, `rsp_data`=captured value, `rsp_error`=0.
- **Poll evaluation (op 10):** at the capture cycle, compare `(avm_readdata & mask) == (cmd_data & mask)`.
  - Match: respond with data and error=0.
  - No match and counter=0: respond with last data and error=1.
  - No match and counter>0: decrement the counter and return to READ on the next cycle.
  - Total reads never exceed `cmd_timeout`+1. A mask of 0 always matches on the first read.
- **RSP_RSV:** no bus activity. Next cycle: `rsp_valid`=1, `rsp_error`=1, `rsp_data`=0.
- **Strobe exclusivity:** read and write strobes are never low together, and neither is low without chipselect.
- **Idle bus outputs:** `avm_address` and `avm_writedata` keep their last values when idle.

## Timing
- **Reset values:**
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_read_n`=1.
  - `avm_address`=0, `avm_writedata`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0.
  - State IDLE, so `cmd_ready`=1.
- **Reset mid-transfer:** strobes deassert asynchronously and no response is produced.
- **Latency,** with the command accepted in cycle C0 and waitrequest=0:
  - Write: strobe in C1, `rsp_valid` in C2.
  - Read with `READ_LATENCY`=1: strobe in C1, capture in C2, `rsp_valid` in C3.
  - Poll: read period is `READ_LATENCY`+1 cycles.
- **Back-to-back commands:** `cmd_ready`=1 in the same cycle as `rsp_valid`. A command accepted there starts its bus strobe the following cycle.
- **Waitrequest:** each cycle of waitrequest=1 adds one cycle of latency. Strobes, address and data are stable throughout.
- **Input changes:** `cmd_*` changes while busy are ignored.

## Test plan
- **Write:** write 0x000000A5 to addr 0, then read addr 0 (PIO model with `in_port` looped from `out_port`). Required: the write strobe lasts 1 cycle, `rsp_valid` arrives at C2 and C3 respectively, and `rsp_data`=0x000000A5.
- **Set/clear registers:** write 0x0F to addr 4 (set), then 0x05 to addr 5 (clear), then read addr 0. Required: `rsp_data`=0x000000AA.
- **Waitrequest:** hold `avm_waitrequest` high 3 cycles on a read. Required: strobe held 4 cycles, address stable, `rsp_valid` at C6.
- **Poll match:** `in_port` becomes 0x80000000 after 5 reads; poll with mask 0x80000000, data 0x80000000, timeout 10. Required: exactly 6 reads, `rsp_error`=0, `rsp_data`=0x80000000.
- **Poll timeout:** never-matching poll with timeout 3. Required: exactly 4 reads, then `rsp_error`=1. Reserved op 11: no strobe, `rsp_error`=1 at C1.
- **Reset mid-operation:** assert `reset_n` low mid-poll. Required: strobes return high in the same cycle, no `rsp_valid`, `cmd_ready`=1 after release.
